bht_update_ctrl: RTL and testbench
==================================

Name: bht_update_ctrl

Overview:
- Controller for the branch-predictor 2-bit saturating-counter table, one counter per index.
- Shares a single-port counter RAM between fetch-stage lookups and EX-stage feedback updates.
- Buffers feedback in a small FIFO and performs read-modify-write updates.
- Sequences table initialisation after reset and on flush.

Parameters:
- INDEX_W, 8, table index width; table depth = 2**INDEX_W.
- QDEPTH, 4, feedback FIFO entries (power of two, >=2).
- INIT_STATE, 2'b01, counter value written to every entry during init (weakly not-taken).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- flush  in  1  restart table initialisation.
- lk_valid  in  1  fetch lookup request.
- lk_index  in  INDEX_W  lookup index.
- lk_ready  out  1  lookup accepted this cycle when lk_valid && lk_ready.
- pred_valid  out  1  prediction valid, one cycle after accept.
- pred_taken  out  1  predicted direction (counter MSB).
- fb_valid  in  1  EX feedback valid (x_predict_res).
- fb_index  in  INDEX_W  index of the resolved branch.
- fb_taken  in  1  resolved outcome.
- fb_ready  out  1  FIFO not full; push when fb_valid && fb_ready.
- init_busy  out  1  init sweep in progress.
- tbl_en  out  1  RAM access enable.
- tbl_we  out  1  RAM write enable.
- tbl_addr  out  INDEX_W  RAM address.
- tbl_wdata  out  2  RAM write data.
- tbl_rdata  in  2  RAM read data, valid the cycle after a read (latency 1).

Behaviour:
- Reset:
  - state=INIT, init address=0, FIFO empty.
  - pred_valid=0, pred_taken=0, init_busy=1.
  - tbl_en=0, tbl_we=0, tbl_addr=0, tbl_wdata=0.
  - fb_ready=1, lk_ready=0.
- FSM states:
  - INIT: one write per cycle; addr 0..2**INDEX_W-1, data INIT_STATE. After writing the last address -> RUN and init_busy=0. 256 cycles at default.
  - RUN: per-cycle priority:
    - (a) lookup if lk_valid and FIFO not full: read lk_index; pred_valid next cycle with pred_taken=tbl_rdata[1].
    - (b) else if FIFO non-empty: read head index -> UPD_WR.
    - (c) else idle, tbl_en=0.
  - UPD_WR: write sat(tbl_rdata, head.taken) to head index, pop FIFO -> RUN. lk_ready=0 in this state.
- lk_ready = (state==RUN) && !fifo_full. When the FIFO is full, updates drain ahead of lookups, so updates cannot starve.
- Saturating counter:
  - taken: 00->01->10->11, 11 holds.
  - not taken: 11->10->01->00, 00 holds.
- FIFO behaviour:
  - Accepts feedback in every state, including INIT.
  - fb_ready = !full. A push when full is not possible; no same-cycle pop-then-push when full.
  - Push and pop in the same cycle when not full: both occur, occupancy unchanged.
  - Pointers wrap modulo QDEPTH; FIFO order is preserved.
- Hazards: lookups read the table contents only. Queued, unapplied updates are not forwarded; a stale prediction is permitted.
- Back-to-back lookups: one per cycle, pred_valid a continuous pulse train.
- Flush (synchronous):
  - Any state -> INIT at addr 0, FIFO cleared.
  - pred_valid for a lookup accepted in the flush cycle is suppressed.
  - An in-flight UPD_WR is abandoned with no write.
  - Flush during INIT restarts the sweep at 0.
- rst mid-operation: immediate return to the reset values above.
- tbl_wdata=0 whenever tbl_we=0.

Optional Feature:
- Macro: BHT_UPDATE_CTRL_STATS_EN.
- When defined, adds outputs stat_lookups, stat_updates and stat_stalls, each 32 bits:
  - stat_lookups: accepted lookups.
  - stat_updates: completed UPD_WR writes.
  - stat_stalls: cycles with lk_valid && !lk_ready in RUN/UPD_WR.
- Counters saturate at 2**32-1 and clear on rst and flush.
- When undefined: ports and logic are absent; the remaining behaviour is identical.

Test Plan:
- Release rst, idle -> exactly 256 writes of 2'b01 to addrs 0..255, then init_busy=0; lookup idx 0x10 -> pred_valid next cycle, pred_taken=0.
- Feedback taken x2 on idx 0x10, no lookups -> read/write pairs write 2'b10 then 2'b11; lookup 0x10 -> pred_taken=1; a further 3 taken keeps 2'b11.
- From 2'b11, send 4 not-taken on idx 0x22 -> writes 10, 01, 00, 00; pred_taken=0 afterwards.
- Continuous lk_valid plus 4 feedback pushes -> FIFO fills, fb_ready=0, lk_ready=0.
  - One entry drains (2 cycles), then lookups resume.
  - No feedback is lost; final counters match the pushes in order.
- Assert flush during UPD_WR with 2 entries queued -> no write that cycle, FIFO empty, init sweep restarts at 0, init_busy=1 for 256 cycles.
- Assert rst at init addr 100 -> all outputs at reset values immediately; after release, init restarts at addr 0.

Source files
------------

// File: rtl/bht_update_ctrl.sv
// bht_update_ctrl: 2-bit BHT counter table controller with a feedback FIFO, read-modify-write updates and init sweep.
// Define BHT_UPDATE_CTRL_STATS_EN to add lookup/update/stall statistics counters.
module bht_update_ctrl #(
    parameter int INDEX_W = 8,
    parameter int QDEPTH = 4,
    parameter logic [1:0] INIT_STATE = 2'b01
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               lk_valid,
    input  logic [INDEX_W-1:0] lk_index,
    output logic               lk_ready,
    output logic               pred_valid,
    output logic               pred_taken,
    input  logic               fb_valid,
    input  logic [INDEX_W-1:0] fb_index,
    input  logic               fb_taken,
    output logic               fb_ready,
    output logic               init_busy,
    output logic               tbl_en,
    output logic               tbl_we,
    output logic [INDEX_W-1:0] tbl_addr,
    output logic [1:0]         tbl_wdata,
    input  logic [1:0]         tbl_rdata
`ifdef BHT_UPDATE_CTRL_STATS_EN
    ,
    output logic [31:0]        stat_lookups,
    output logic [31:0]        stat_updates,
    output logic [31:0]        stat_stalls
`endif
);
    localparam int PW = $clog2(QDEPTH);
    localparam logic [PW:0] QFULL = (PW+1)'(QDEPTH);

    typedef enum logic [1:0] {S_INIT, S_RUN, S_UPD_WR} state_t;

    state_t state, state_n;
    logic [INDEX_W-1:0] init_addr;
    logic [INDEX_W-1:0] q_index [QDEPTH];
    logic q_taken [QDEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0] count;
    logic full, empty, push, pop, lk_acc;

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        return t ? ((c == 2'b11) ? c : c + 2'd1) : ((c == 2'b00) ? c : c - 2'd1);
    endfunction

    assign full = count == QFULL;
    assign empty = count == '0;
    assign fb_ready = !full;
    assign push = fb_valid && !full;
    assign pop = (state == S_UPD_WR) && !flush;
    assign lk_ready = (state == S_RUN) && !full;
    assign lk_acc = lk_valid && lk_ready;
    assign init_busy = state == S_INIT;
    assign pred_taken = pred_valid && tbl_rdata[1];

    always_comb begin
        state_n = state;
        tbl_en = 1'b0;
        tbl_we = 1'b0;
        tbl_addr = '0;
        tbl_wdata = 2'b00;
        case (state)
            S_INIT: begin
                tbl_en = 1'b1;
                tbl_we = 1'b1;
                tbl_addr = init_addr;
                tbl_wdata = INIT_STATE;
                state_n = (init_addr == '1) ? S_RUN : S_INIT;
            end
            S_RUN: begin
                if (lk_acc) begin
                    tbl_en = 1'b1;
                    tbl_addr = lk_index;
                end else if (!empty) begin
                    tbl_en = 1'b1;
                    tbl_addr = q_index[rd_ptr];
                    state_n = S_UPD_WR;
                end
            end
            S_UPD_WR: begin
                tbl_en = 1'b1;
                tbl_we = 1'b1;
                tbl_addr = q_index[rd_ptr];
                tbl_wdata = sat(tbl_rdata, q_taken[rd_ptr]);
                state_n = S_RUN;
            end
            default: state_n = S_INIT;
        endcase
        // Outputs must read as idle while reset is held and on the flush cycle (abandons any write).
        if (rst || flush) begin
            tbl_en = 1'b0;
            tbl_we = 1'b0;
            tbl_addr = '0;
            tbl_wdata = 2'b00;
            state_n = S_INIT;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_INIT;
            init_addr <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count <= '0;
            pred_valid <= 1'b0;
        end else begin
            state <= state_n;
            pred_valid <= lk_acc && !flush;
            init_addr <= flush ? '0 : (state == S_INIT) ? init_addr + 1'b1 : init_addr;
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count <= '0;
            end else begin
                wr_ptr <= wr_ptr + PW'(push);
                rd_ptr <= rd_ptr + PW'(pop);
                count <= count + (PW+1)'(push) - (PW+1)'(pop);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            q_index[wr_ptr] <= fb_index;
            q_taken[wr_ptr] <= fb_taken;
        end
    end

`ifdef BHT_UPDATE_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_lookups <= '0;
            stat_updates <= '0;
            stat_stalls <= '0;
        end else if (flush) begin
            stat_lookups <= '0;
            stat_updates <= '0;
            stat_stalls <= '0;
        end else begin
            if (lk_acc && stat_lookups != '1) stat_lookups <= stat_lookups + 1'b1;
            if (pop && stat_updates != '1) stat_updates <= stat_updates + 1'b1;
            if (lk_valid && !lk_ready && state != S_INIT && stat_stalls != '1) stat_stalls <= stat_stalls + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_bht_update_ctrl.sv
// tb_bht_update_ctrl: directed stimulus with a queue/table reference model checked every cycle,
// plus literal expectations on counters, handshakes and init sweep length.
module tb_bht_update_ctrl;
    logic clk = 0, rst = 1, flush = 0;
    logic lk_valid = 0, fb_valid = 0, fb_taken = 0;
    logic [7:0] lk_index = 0, fb_index = 0;
    logic lk_ready, pred_valid, pred_taken, fb_ready, init_busy, tbl_en, tbl_we;
    logic [7:0] tbl_addr;
    logic [1:0] tbl_wdata, tbl_rdata = 2'b00;
    int checks = 0, errors = 0, init_wr = 0;

    bht_update_ctrl dut (
        .clk(clk), .rst(rst), .flush(flush),
        .lk_valid(lk_valid), .lk_index(lk_index), .lk_ready(lk_ready),
        .pred_valid(pred_valid), .pred_taken(pred_taken),
        .fb_valid(fb_valid), .fb_index(fb_index), .fb_taken(fb_taken), .fb_ready(fb_ready),
        .init_busy(init_busy), .tbl_en(tbl_en), .tbl_we(tbl_we), .tbl_addr(tbl_addr),
        .tbl_wdata(tbl_wdata), .tbl_rdata(tbl_rdata)
    );

    always #5 clk = ~clk;

    // Single-port table RAM with one-cycle read latency; starts as 2'b11 so a missed init shows up.
    logic [1:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = 2'b11;
    always @(posedge clk) begin
        if (tbl_en && tbl_we) mem[tbl_addr] <= tbl_wdata;
        else if (tbl_en) tbl_rdata <= mem[tbl_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] sat(input logic [1:0] c, input logic t);
        int v;
        v = t ? int'(c) + 1 : int'(c) - 1;
        if (v > 3) v = 3;
        if (v < 0) v = 0;
        return v[1:0];
    endfunction

    // Reference model: pending feedback queue, expected table contents, and a pending prediction.
    typedef struct packed {logic [7:0] idx; logic t;} fb_t;
    fb_t q[$];
    logic [1:0] exp_tbl [256];
    bit m_init = 1, m_upd = 0, m_pv = 0, m_pt = 0;
    logic [7:0] m_addr = 0;
    bit m_full, m_lkr, m_rdlk;
    logic e_en, e_we;
    logic [7:0] e_addr;
    logic [1:0] e_wd;

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_tbl_en", tbl_en, 0);
            chk("rst_tbl_we", tbl_we, 0);
            chk("rst_tbl_addr", tbl_addr, 0);
            chk("rst_tbl_wdata", tbl_wdata, 0);
            chk("rst_pred_valid", pred_valid, 0);
            chk("rst_pred_taken", pred_taken, 0);
            chk("rst_init_busy", init_busy, 1);
            chk("rst_fb_ready", fb_ready, 1);
            chk("rst_lk_ready", lk_ready, 0);
            m_init = 1; m_addr = 0; m_upd = 0; m_pv = 0; m_pt = 0;
            q.delete();
        end else begin
            if (tbl_we && init_busy) init_wr++;
            m_full = q.size() == 4;
            m_lkr = !m_init && !m_upd && !m_full;
            m_rdlk = m_lkr && lk_valid;
            {e_en, e_we, e_addr, e_wd} = '0;
            if (!flush) begin
                if (m_init) {e_en, e_we, e_addr, e_wd} = {2'b11, m_addr, 2'b01};
                else if (m_upd) {e_en, e_we, e_addr, e_wd} = {2'b11, q[0].idx, sat(exp_tbl[q[0].idx], q[0].t)};
                else if (m_rdlk) {e_en, e_we, e_addr, e_wd} = {2'b10, lk_index, 2'b00};
                else if (q.size() > 0) {e_en, e_we, e_addr, e_wd} = {2'b10, q[0].idx, 2'b00};
            end
            chk("lk_ready", lk_ready, m_lkr);
            chk("fb_ready", fb_ready, !m_full);
            chk("init_busy", init_busy, m_init);
            chk("tbl_en", tbl_en, e_en);
            chk("tbl_we", tbl_we, e_we);
            chk("tbl_addr", tbl_addr, e_addr);
            chk("tbl_wdata", tbl_wdata, e_wd);
            chk("pred_valid", pred_valid, m_pv);
            chk("pred_taken", pred_taken, m_pv && m_pt);
            m_pv = m_rdlk && !flush;
            m_pt = exp_tbl[lk_index][1];
            if (flush) begin
                m_init = 1; m_addr = 0; m_upd = 0;
                q.delete();
            end else begin
                if (m_init) begin
                    exp_tbl[m_addr] = 2'b01;
                    if (m_addr == 8'hff) m_init = 0;
                    m_addr = m_addr + 1;
                end else if (m_upd) begin
                    exp_tbl[q[0].idx] = sat(exp_tbl[q[0].idx], q[0].t);
                    void'(q.pop_front());
                    m_upd = 0;
                end else if (!m_rdlk && q.size() > 0) m_upd = 1;
                if (fb_valid && !m_full) q.push_back({fb_index, fb_taken});
            end
        end
    end

    task automatic drive(input logic lv, input logic [7:0] li, input logic fv, input logic [7:0] fi, input logic ft, input logic fl);
        @(posedge clk);
        #1;
        lk_valid = lv; lk_index = li; fb_valid = fv; fb_index = fi; fb_taken = ft; flush = fl;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, 0);
    endtask

    task automatic wait_init();
        int n = 0;
        while (init_busy && n < 400) begin
            drive(0, 0, 0, 0, 0, 0);
            n++;
        end
        chk("init_done", init_busy, 0);
    endtask

    task automatic lookup(input logic [7:0] idx, input logic exp_taken, input string name);
        drive(1, idx, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk({name, "_pv"}, pred_valid, 1);
        chk({name, "_pt"}, pred_taken, exp_taken);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) exp_tbl[i] = 2'b11;
        idle(3);
        @(posedge clk); #1 rst = 0;
        wait_init();
        chk("init_writes", init_wr, 256);
        lookup(8'h10, 0, "lk10_init");

        for (int i = 0; i < 2; i++) drive(0, 0, 1, 8'h10, 1, 0);
        idle(6);
        chk("mem10_after2T", mem[8'h10], 2'b11);
        chk("model10_after2T", exp_tbl[8'h10], 2'b11);
        lookup(8'h10, 1, "lk10_taken");
        for (int i = 0; i < 3; i++) drive(0, 0, 1, 8'h10, 1, 0);
        idle(8);
        chk("mem10_saturated", mem[8'h10], 2'b11);

        for (int i = 0; i < 2; i++) drive(0, 0, 1, 8'h22, 1, 0);
        idle(6);
        chk("mem22_at3", mem[8'h22], 2'b11);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 8'h22, 0, 0);
        idle(10);
        chk("mem22_at0", mem[8'h22], 2'b00);
        lookup(8'h22, 0, "lk22_nt");

        drive(1, 8'h01, 1, 8'h30, 1, 0);
        drive(1, 8'h10, 1, 8'h31, 1, 0);
        drive(1, 8'h02, 1, 8'h30, 1, 0);
        drive(1, 8'h10, 1, 8'h30, 0, 0);
        drive(1, 8'h03, 0, 0, 0, 0);
        @(negedge clk);
        chk("full_fb_ready", fb_ready, 0);
        chk("full_lk_ready", lk_ready, 0);
        drive(1, 8'h04, 0, 0, 0, 0);
        @(negedge clk);
        chk("upd_lk_ready", lk_ready, 0);
        drive(1, 8'h05, 0, 0, 0, 0);
        @(negedge clk);
        chk("resume_lk_ready", lk_ready, 1);
        for (int i = 0; i < 10; i++) drive(1, 8'(i * 7), 0, 0, 0, 0);
        idle(10);
        chk("mem30_final", mem[8'h30], 2'b10);
        chk("mem31_final", mem[8'h31], 2'b10);

        drive(0, 0, 1, 8'h40, 1, 0);
        drive(0, 0, 1, 8'h41, 1, 0);
        drive(0, 0, 0, 0, 0, 1);
        init_wr = 0;
        @(negedge clk);
        chk("flush_no_we", tbl_we, 0);
        chk("flush_no_en", tbl_en, 0);
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_init_busy", init_busy, 1);
        chk("flush_addr0", tbl_addr, 0);
        chk("flush_fifo_empty", fb_ready, 1);
        wait_init();
        chk("flush_init_writes", init_wr, 256);
        chk("mem40_reinit", mem[8'h40], 2'b01);
        chk("mem10_reinit", mem[8'h10], 2'b01);

        drive(1, 8'h10, 0, 0, 0, 1);
        @(negedge clk);
        chk("flush_lk_ready", lk_ready, 1);
        init_wr = 0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        chk("flush_pred_suppressed", pred_valid, 0);
        idle(99);
        @(posedge clk); #1 rst = 1;
        @(negedge clk);
        chk("rst_mid_addr", tbl_addr, 0);
        chk("rst_mid_en", tbl_en, 0);
        chk("rst_mid_busy", init_busy, 1);
        chk("writes_before_rst", init_wr, 100);
        idle(2);
        @(posedge clk); #1 rst = 0;
        init_wr = 0;
        @(negedge clk);
        chk("rst_restart_addr", tbl_addr, 0);
        chk("rst_restart_we", tbl_we, 1);
        wait_init();
        chk("rst_init_writes", init_wr, 256);
        lookup(8'h22, 0, "lk22_reinit");
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
